// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
//   Handshake and data bundle for the bit-serial adder controller.
//   Optional feature macro: SERIAL_SUB_EN (adds the 'sub' request field).
//
//   Signals
//     start  request, seen by the controller only when it is not running
//     A, B   WIDTH-bit operands, captured with an accepted start
//     sub    subtract select, captured with start (SERIAL_SUB_EN only)
//     busy   high while the serial add is in progress
//     done   one-cycle pulse, S/Cout valid
//     S      WIDTH-bit result, held until the next accepted start
//     Cout   final carry-out (no-borrow flag when subtracting), held with S
//
//   Modports
//     master  requester side: drives start/A/B(/sub), observes the results
//     slave   controller side
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output start,
    output A,
    output B,
`ifdef SERIAL_SUB_EN
    output sub,
`endif
    input  busy,
    input  done,
    input  S,
    input  Cout
  );

  modport slave (
    input  start,
    input  A,
    input  B,
`ifdef SERIAL_SUB_EN
    input  sub,
`endif
    output busy,
    output done,
    output S,
    output Cout
  );

endinterface : serial_adder_ctrl_if

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder built around a single full-adder cell.
//   Operands are latched on an accepted start and fed LSB-first, one bit per
//   clock; the ripple carry lives in a flop between bits and the sum is
//   assembled in a right-shifting register. Result appears WIDTH cycles after
//   the start edge, flagged by a one-cycle done pulse.
//
//   Optional feature macro: SERIAL_SUB_EN
//     defined   : bus.sub=1 computes A-B (B inverted, carry-in 1);
//                 Cout=1 then means no borrow (A >= B unsigned)
//     undefined : addition only, no sub field on the bus
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    serial_adder_ctrl_if.slave (start/A/B[/sub] in, busy/done/S/Cout out)
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  // The one full-adder cell: current LSBs plus the stored ripple carry.
  logic fa_s;
  logic fa_cout;

  assign fa_s    = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_cout = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

  // busy/done come straight from flops updated alongside the state, so they
  // are glitch-free and mutually exclusive by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here uses non-blocking assignment so all of them
    // sample the pre-edge values (the adder reads a_sh/b_sh/carry while they
    // are being shifted on the same edge).
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        // DONE behaves like IDLE for accepting a new request, which gives
        // back-to-back operation without a dead cycle.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.A;
            cnt    <= '0;
`ifdef SERIAL_SUB_EN
            // A - B as A + ~B + 1: invert B and seed the carry with 1.
            b_sh   <= bus.sub ? ~bus.B : bus.B;
            carry  <= bus.sub;
`else
            b_sh   <= bus.B;
            carry  <= 1'b0;
`endif
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            cout_q <= fa_cout;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = sum_sh;
  assign bus.Cout = cout_q;

endmodule : serial_adder_ctrl
